ldm_stm_seq: RTL and testbench

- Multi-register load/store sequencer for ARMv4 LDM/STM.
- Sits directly upstream of the register bank's write port, and beside its read port.
- Walks a 16-bit register list and issues one word transfer per set bit on a simple req/ack memory bus.
- On loads it drives the bank's Rd/data_in/latch_reg; on stores it selects a bank read port and forwards its data to memory. Handles optional base writeback.

---
 rtl/ldm_stm_seq.sv | 198 +++++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_seq.sv
// ARMv4 LDM/STM sequencer: walks a register list, one bus word per set bit, drives the bank write port.
// Optional LDM_STM_ABORT_EN adds mem_abort/abort for terminating a sequence on a faulted transfer.
module ldm_stm_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              wback,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_val,
  input  logic [15:0]       reg_list,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [3:0]        rb_rd,
  output logic [ADDR_W-1:0] rb_data,
  output logic              rb_latch,
  output logic [3:0]        rb_rsel,
  input  logic [ADDR_W-1:0] rb_rdata
`ifdef LDM_STM_ABORT_EN
  ,
  input  logic              mem_abort,
  output logic              abort
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, WBACK, FIN} state_t;

  state_t            state_q;
  logic              busy_q, done_q, mem_req_q, mem_we_q, rb_latch_q;
  logic [ADDR_W-1:0] mem_addr_q, rb_data_q;
  logic [3:0]        rb_rd_q, rb_rsel_q;
  logic              is_load_q, up_q, pre_q, do_wb_q;
  logic [3:0]        base_reg_q;
  logic [ADDR_W-1:0] base_q, addr_q, wb_val_q;
  logic [15:0]       list_q;

  logic [3:0]        idx;
  logic [4:0]        cnt;
  logic [15:0]       rest;
  logic [ADDR_W-1:0] n4, start_addr, wb_val_d;
  logic              abort_hit;

`ifdef LDM_STM_ABORT_EN
  logic abort_q;
  assign abort_hit = mem_abort;
  assign abort     = abort_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Lowest set bit is the next register: ascending index pairs with ascending address.
  always_comb begin
    idx = '0;
    cnt = '0;
    for (int i = 15; i >= 0; i--)
      if (list_q[i]) idx = 4'(i);
    for (int i = 0; i < 16; i++)
      cnt = cnt + 5'(list_q[i]);
  end

  assign rest = list_q & ~(16'd1 << idx);
  assign n4   = ADDR_W'(cnt) << 2;

  always_comb begin
    case ({up_q, pre_q})
      2'b10:   start_addr = base_q;
      2'b11:   start_addr = base_q + ADDR_W'(4);
      2'b00:   start_addr = base_q - n4 + ADDR_W'(4);
      default: start_addr = base_q - n4;
    endcase
    wb_val_d = up_q ? base_q + n4 : base_q - n4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      rb_latch_q <= 1'b0;
      mem_addr_q <= '0;
      rb_data_q  <= '0;
      rb_rd_q    <= '0;
      rb_rsel_q  <= '0;
      is_load_q  <= 1'b0;
      up_q       <= 1'b0;
      pre_q      <= 1'b0;
      do_wb_q    <= 1'b0;
      base_reg_q <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      wb_val_q   <= '0;
      list_q     <= '0;
`ifdef LDM_STM_ABORT_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      rb_latch_q <= 1'b0;
`ifdef LDM_STM_ABORT_EN
      abort_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: if (start) begin
          is_load_q  <= is_load;
          up_q       <= up;
          pre_q      <= pre;
          // A load that includes the base keeps the loaded value, so writeback is dropped.
          do_wb_q    <= wback & ~(is_load & reg_list[base_reg]);
          base_reg_q <= base_reg;
          base_q     <= base_val & ~ADDR_W'(3);
          list_q     <= reg_list;
          busy_q     <= 1'b1;
          state_q    <= SETUP;
        end
        SETUP: begin
          wb_val_q <= wb_val_d;
          if (list_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FIN;
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= ~is_load_q;
            mem_addr_q <= start_addr;
            addr_q     <= start_addr + ADDR_W'(4);
            rb_rsel_q  <= idx;
            state_q    <= XFER;
          end
        end
        XFER: begin
          if (mem_req_q) begin
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              list_q    <= rest;
              if (abort_hit) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= FIN;
`ifdef LDM_STM_ABORT_EN
                abort_q <= 1'b1;
`endif
              end else begin
                if (is_load_q) begin
                  rb_latch_q <= 1'b1;
                  rb_rd_q    <= idx;
                  rb_data_q  <= mem_rdata;
                end
                if (rest == '0) state_q <= WBACK;
              end
            end
          end else begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= addr_q;
            addr_q     <= addr_q + ADDR_W'(4);
            rb_rsel_q  <= idx;
          end
        end
        // The final load latch is on the bank during this cycle; writeback follows it.
        WBACK: begin
          if (do_wb_q) begin
            rb_latch_q <= 1'b1;
            rb_rd_q    <= base_reg_q;
            rb_data_q  <= wb_val_q;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= FIN;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = (mem_req_q & mem_we_q) ? rb_rdata : '0;
  assign rb_rd     = rb_rd_q;
  assign rb_data   = rb_data_q;
  assign rb_latch  = rb_latch_q;
  assign rb_rsel   = rb_rsel_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: bus responder with programmable ack delay, bank read model, event logs.
module tb_ldm_stm_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, is_load = 1'b0, up = 1'b0, pre = 1'b0, wback = 1'b0;
  logic [3:0]  base_reg = '0;
  logic [31:0] base_val = '0;
  logic [15:0] reg_list = '0;
  logic        busy, done, mem_req, mem_we, mem_ack, rb_latch;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rb_data, rb_rdata;
  logic [3:0]  rb_rd, rb_rsel;
`ifdef LDM_STM_ABORT_EN
  logic        mem_abort, abort;
  logic        abort_on = 1'b0;
  int          ack_base = 0;
  int          abort_done = 0;
`endif

  int checks = 0, failures = 0;
  int ack_dly = 0, wait_cnt = 0, acks_seen = 0;
  int cyc = 0, done_cnt = 0, stall_err = 0, last_latch_cyc = 0, last_done_cyc = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = '0, prev_wd = '0;
  logic [31:0] bus_addr[$], bus_dat[$], lat_dat[$];
  logic        bus_we[$];
  logic [3:0]  lat_rd[$];

  always #5 clk = ~clk;

  ldm_stm_seq #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .up(up), .pre(pre),
    .wback(wback), .base_reg(base_reg), .base_val(base_val), .reg_list(reg_list),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rb_rd(rb_rd),
    .rb_data(rb_data), .rb_latch(rb_latch), .rb_rsel(rb_rsel), .rb_rdata(rb_rdata)
`ifdef LDM_STM_ABORT_EN
    , .mem_abort(mem_abort), .abort(abort)
`endif
  );

  assign rb_rdata  = 32'hB000_0000 | {28'd0, rb_rsel};
  assign mem_rdata = 32'hA000_0000 | mem_addr;
  assign mem_ack   = mem_req && (wait_cnt >= ack_dly);
`ifdef LDM_STM_ABORT_EN
  assign mem_abort = abort_on && mem_ack && ((acks_seen - ack_base) == 1);
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (rst_n && mem_ack) acks_seen <= acks_seen + 1;
  end

  // Event logger: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_req && mem_ack) begin
      bus_addr.push_back(mem_addr);
      bus_we.push_back(mem_we);
      bus_dat.push_back(mem_we ? mem_wdata : mem_rdata);
    end
    if (rb_latch) begin
      lat_rd.push_back(rb_rd);
      lat_dat.push_back(rb_data);
      last_latch_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (prev_req && !prev_ack && mem_req && (mem_addr !== prev_addr || mem_wdata !== prev_wd))
      stall_err = stall_err + 1;
`ifdef LDM_STM_ABORT_EN
    if (abort && done) abort_done = abort_done + 1;
`endif
    prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr; prev_wd = mem_wdata;
  end

  task automatic run_op(input logic ld, input logic u, input logic p, input logic w,
                        input logic [3:0] rn, input logic [31:0] bv, input logic [15:0] lst,
                        output int lat, output logic busy1);
    @(negedge clk);
    is_load = ld; up = u; pre = p; wback = w; base_reg = rn; base_val = bv; reg_list = lst;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    lat = 1;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] a;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_req, mem_we, rb_latch} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 00000", {busy, done, mem_req, mem_we, rb_latch});
    end
    a = mem_addr | mem_wdata | rb_data | {28'd0, rb_rd} | {28'd0, rb_rsel};
    checks++;
    if (a !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: or of data outputs %h required 0", a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, mem_req, rb_latch} !== 3'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b required 000", {busy, mem_req, rb_latch});
    end
  endtask

  task automatic test_ldmia();
    int b0, l0, lat;
    logic bz;
    logic [31:0] ea[3];
    logic [3:0]  er[3];
    ea = '{32'h100, 32'h104, 32'h108};
    er = '{4'd0, 4'd1, 4'd3};
    b0 = bus_addr.size(); l0 = lat_rd.size();
    run_op(1, 1, 0, 0, 4'd5, 32'h100, 16'h000B, lat, bz);
    checks++;
    if (bus_addr.size() - b0 != 3 || lat_rd.size() - l0 != 3) begin
      failures++;
      $display("FAIL ldmia_counts: bus=%0d latch=%0d required 3/3", bus_addr.size() - b0, lat_rd.size() - l0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (bus_addr[b0+i] !== ea[i] || bus_we[b0+i] !== 1'b0 || lat_rd[l0+i] !== er[i] ||
            lat_dat[l0+i] !== (32'hA000_0000 | ea[i])) begin
          failures++;
          $display("FAIL ldmia_xfer%0d: addr=%h we=%b rd=%0d data=%h required addr=%h we=0 rd=%0d data=%h",
                   i, bus_addr[b0+i], bus_we[b0+i], lat_rd[l0+i], lat_dat[l0+i], ea[i], er[i], 32'hA000_0000 | ea[i]);
        end
      end
    end
    checks++;
    if (last_done_cyc <= last_latch_cyc) begin
      failures++;
      $display("FAIL ldmia_done_order: done cycle %0d latch cycle %0d, required done later", last_done_cyc, last_latch_cyc);
    end
  endtask

  task automatic test_stmdb_wback();
    int b0, l0, lat;
    logic bz;
    logic [31:0] ea[3], ed[3];
    ea = '{32'h1F4, 32'h1F8, 32'h1FC};
    ed = '{32'hB000_0004, 32'hB000_0005, 32'hB000_000E};
    b0 = bus_addr.size(); l0 = lat_rd.size();
    run_op(0, 0, 1, 1, 4'd13, 32'h200, 16'h4030, lat, bz);
    checks++;
    if (bus_addr.size() - b0 != 3) begin
      failures++;
      $display("FAIL stmdb_count: bus=%0d required 3", bus_addr.size() - b0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (bus_addr[b0+i] !== ea[i] || bus_we[b0+i] !== 1'b1 || bus_dat[b0+i] !== ed[i]) begin
          failures++;
          $display("FAIL stmdb_xfer%0d: addr=%h we=%b wdata=%h required addr=%h we=1 wdata=%h",
                   i, bus_addr[b0+i], bus_we[b0+i], bus_dat[b0+i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (lat_rd.size() - l0 != 1) begin
      failures++;
      $display("FAIL stmdb_wb_count: latches=%0d required 1", lat_rd.size() - l0);
    end else if (lat_rd[l0] !== 4'd13 || lat_dat[l0] !== 32'h1F4) begin
      failures++;
      $display("FAIL stmdb_wb: rd=%0d data=%h required rd=13 data=000001f4", lat_rd[l0], lat_dat[l0]);
    end
  endtask

  task automatic test_ldmib_base_in_list();
    int b0, l0, lat;
    logic bz;
    b0 = bus_addr.size(); l0 = lat_rd.size();
    run_op(1, 1, 1, 1, 4'd2, 32'h40, 16'h0006, lat, bz);
    checks++;
    if (bus_addr.size() - b0 != 2 || lat_rd.size() - l0 != 2) begin
      failures++;
      $display("FAIL ldmib_counts: bus=%0d latch=%0d required 2/2", bus_addr.size() - b0, lat_rd.size() - l0);
    end else begin
      checks++;
      if (bus_addr[b0] !== 32'h44 || bus_addr[b0+1] !== 32'h48) begin
        failures++;
        $display("FAIL ldmib_addr: %h %h required 00000044 00000048", bus_addr[b0], bus_addr[b0+1]);
      end
      checks++;
      if (lat_rd[l0] !== 4'd1 || lat_dat[l0] !== 32'hA000_0044 || lat_rd[l0+1] !== 4'd2 || lat_dat[l0+1] !== 32'hA000_0048) begin
        failures++;
        $display("FAIL ldmib_latch: R%0d=%h R%0d=%h required R1=a0000044 R2=a0000048",
                 lat_rd[l0], lat_dat[l0], lat_rd[l0+1], lat_dat[l0+1]);
      end
    end
  endtask

  task automatic test_empty_list();
    int b0, l0, lat;
    logic bz;
    b0 = bus_addr.size(); l0 = lat_rd.size();
    run_op(1, 1, 0, 1, 4'd3, 32'h80, 16'h0000, lat, bz);
    checks++;
    if (bz !== 1'b1 || lat != 2) begin
      failures++;
      $display("FAIL empty_timing: busy=%b done_latency=%0d required busy=1 latency=2", bz, lat);
    end
    checks++;
    if (bus_addr.size() != b0 || lat_rd.size() != l0) begin
      failures++;
      $display("FAIL empty_activity: bus=%0d latch=%0d required 0/0", bus_addr.size() - b0, lat_rd.size() - l0);
    end
  endtask

  task automatic test_wrap_r15();
    int b0, l0, lat;
    logic bz;
    b0 = bus_addr.size(); l0 = lat_rd.size();
    run_op(1, 0, 1, 1, 4'd4, 32'h0000_0003, 16'h8001, lat, bz);
    checks++;
    if (bus_addr.size() - b0 != 2 || lat_rd.size() - l0 != 3) begin
      failures++;
      $display("FAIL wrap_counts: bus=%0d latch=%0d required 2/3", bus_addr.size() - b0, lat_rd.size() - l0);
    end else begin
      checks++;
      if (bus_addr[b0] !== 32'hFFFF_FFF8 || bus_addr[b0+1] !== 32'hFFFF_FFFC) begin
        failures++;
        $display("FAIL wrap_addr: %h %h required fffffff8 fffffffc", bus_addr[b0], bus_addr[b0+1]);
      end
      checks++;
      if (lat_rd[l0+1] !== 4'd15 || lat_dat[l0+1] !== 32'hFFFF_FFFC || lat_rd[l0+2] !== 4'd4 || lat_dat[l0+2] !== 32'hFFFF_FFF8) begin
        failures++;
        $display("FAIL wrap_latch: R%0d=%h R%0d=%h required R15=fffffffc R4=fffffff8",
                 lat_rd[l0+1], lat_dat[l0+1], lat_rd[l0+2], lat_dat[l0+2]);
      end
    end
  endtask

`ifdef LDM_STM_ABORT_EN
  task automatic test_abort();
    int b0, l0, a0, lat;
    logic bz;
    b0 = bus_addr.size(); l0 = lat_rd.size(); a0 = abort_done;
    ack_base = acks_seen;
    abort_on = 1'b1;
    run_op(1, 0, 0, 1, 4'd5, 32'h30, 16'h0007, lat, bz);
    abort_on = 1'b0;
    checks++;
    if (bus_addr.size() - b0 != 2 || lat_rd.size() - l0 != 1) begin
      failures++;
      $display("FAIL abort_counts: bus=%0d latch=%0d required 2/1", bus_addr.size() - b0, lat_rd.size() - l0);
    end else if (lat_rd[l0] !== 4'd0 || lat_dat[l0] !== 32'hA000_0028 || bus_addr[b0+1] !== 32'h2C) begin
      failures++;
      $display("FAIL abort_latch: R%0d=%h addr2=%h required R0=a0000028 addr2=0000002c", lat_rd[l0], lat_dat[l0], bus_addr[b0+1]);
    end
    checks++;
    if (abort_done - a0 != 1) begin
      failures++;
      $display("FAIL abort_with_done: %0d pulses required 1", abort_done - a0);
    end
  endtask
`endif

  task automatic test_stall_restart_reset();
    int b0, l0, d0, s0, n;
    b0 = bus_addr.size(); l0 = lat_rd.size(); d0 = done_cnt; s0 = stall_err;
    ack_dly = 3;
    @(negedge clk);
    is_load = 0; up = 1; pre = 0; wback = 1; base_reg = 4'd9; base_val = 32'h1000; reg_list = 16'h00F0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (bus_addr.size() < b0 + 1 && n < 50) begin @(negedge clk); n++; end
    start = 1'b1; is_load = 1; base_val = 32'h0; reg_list = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (bus_addr.size() < b0 + 2 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (!mem_req && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL stall_midop: busy=%b mem_req=%b required 1/1", busy, mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, mem_req, rb_latch} !== 3'b0) begin
      failures++;
      $display("FAIL async_reset: busy/req/latch=%b required 000", {busy, mem_req, rb_latch});
    end
    checks++;
    if (bus_addr.size() - b0 != 2 || stall_err != s0) begin
      failures++;
      $display("FAIL stall_bus: acks=%0d stall_errs=%0d required 2/0", bus_addr.size() - b0, stall_err - s0);
    end else if (bus_addr[b0] !== 32'h1000 || bus_addr[b0+1] !== 32'h1004 ||
                 bus_dat[b0] !== 32'hB000_0004 || bus_dat[b0+1] !== 32'hB000_0005) begin
      failures++;
      $display("FAIL stall_data: %h=%h %h=%h required 00001000=b0000004 00001004=b0000005",
               bus_addr[b0], bus_dat[b0], bus_addr[b0+1], bus_dat[b0+1]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ack_dly = 0;
    @(negedge clk);
    checks++;
    if (lat_rd.size() != l0 || done_cnt != d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_abandon: latches=%0d dones=%0d busy=%b required 0/0/0",
               lat_rd.size() - l0, done_cnt - d0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_ldmia();
    test_stmdb_wback();
    test_ldmib_base_in_list();
    test_empty_list();
    test_wrap_r15();
`ifdef LDM_STM_ABORT_EN
    test_abort();
`endif
    test_stall_restart_reset();
    test_ldmia();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
